// File: rtl/afifo_pkg.sv
// Shared definitions for the byte-in/word-out async FIFO and its write-side scheduler.
package afifo_pkg;

    localparam int AFIFO_DSIZE = 8;
    localparam int AFIFO_RATIO = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_PAD   = 2'd2
    } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, wrapping, first hit wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any            = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afifo_wr_sched.sv
// Round-robin write scheduler: grants one byte source an atomic BURST-beat slot on the
// afifo write port, padding the slot with PAD_BYTE if the source stalls too long.
module afifo_wr_sched
    import afifo_pkg::*;
#(
    parameter int             N_REQ    = 4,
    parameter int             DW       = AFIFO_DSIZE,
    parameter int             BURST    = AFIFO_RATIO,
    parameter int             TIMEOUT  = 16,
    parameter logic [DW-1:0]  PAD_BYTE = '0,
    parameter int             CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         s_valid,
    input  logic [N_REQ*DW-1:0]      s_data,
    output logic [N_REQ-1:0]         s_ready,
    input  logic                     fifo_wfull,
    output logic                     fifo_wren,
    output logic [DW-1:0]            fifo_wdata,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         pad_cnt,
    output logic [1:0]               state_dbg
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] SRC_LAST  = IW'(N_REQ - 1);

    wr_state_e        state, state_nx;
    logic [IW-1:0]    rr_ptr, rr_ptr_nx, grant_nx;
    logic [N_REQ-1:0] grant_oh, grant_oh_nx;
    logic [BW-1:0]    beat_cnt, beat_nx;
    logic [TW-1:0]    idle_cnt, idle_nx;
    logic [CNT_W-1:0] pad_nx;
    logic [IW-1:0]    next_src;

    logic [N_REQ-1:0] arb_oh;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req       (s_valid),
        .ptr       (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign next_src  = (grant_id == SRC_LAST) ? '0 : grant_id + 1'b1;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            grant_oh <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            pad_cnt  <= '0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_ptr_nx;
            grant_id <= grant_nx;
            grant_oh <= grant_oh_nx;
            beat_cnt <= beat_nx;
            idle_cnt <= idle_nx;
            pad_cnt  <= pad_nx;
        end
    end

    // idle_cnt only charges cycles where the FIFO could have accepted but the source had nothing.
    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        grant_nx    = grant_id;
        grant_oh_nx = grant_oh;
        beat_nx     = beat_cnt;
        idle_nx     = idle_cnt;
        pad_nx      = pad_cnt;
        case (state)
            ST_IDLE: begin
                beat_nx = '0;
                idle_nx = '0;
                if (arb_any) begin
                    state_nx    = ST_BURST;
                    grant_nx    = arb_idx;
                    grant_oh_nx = arb_oh;
                end
            end
            ST_BURST: begin
                if (fifo_wren) begin
                    idle_nx = '0;
                    if (beat_cnt == BEAT_LAST) begin
                        state_nx  = ST_IDLE;
                        beat_nx   = '0;
                        rr_ptr_nx = next_src;
                    end else begin
                        beat_nx = beat_cnt + 1'b1;
                    end
                end else if (!fifo_wfull) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_nx = ST_PAD;
                        idle_nx  = '0;
                    end else begin
                        idle_nx = idle_cnt + 1'b1;
                    end
                end
            end
            ST_PAD: begin
                if (fifo_wren) begin
                    if (beat_cnt == BEAT_LAST) begin
                        state_nx  = ST_IDLE;
                        beat_nx   = '0;
                        rr_ptr_nx = next_src;
                        pad_nx    = (pad_cnt == '1) ? pad_cnt : pad_cnt + 1'b1;
                    end else begin
                        beat_nx = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake: a beat moves when s_valid[i] & s_ready[i]; ready is offered only to the
    // granted source and only while the FIFO has room, so wren can never hit a full FIFO.
    always_comb begin
        s_ready    = '0;
        fifo_wren  = 1'b0;
        fifo_wdata = '0;
        busy       = 1'b0;
        case (state)
            ST_BURST: begin
                busy       = 1'b1;
                s_ready    = grant_oh & {N_REQ{!fifo_wfull}};
                fifo_wren  = |(s_valid & grant_oh) & !fifo_wfull;
                fifo_wdata = s_data[int'(grant_id)*DW +: DW];
            end
            ST_PAD: begin
                busy       = 1'b1;
                fifo_wren  = !fifo_wfull;
                fifo_wdata = PAD_BYTE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_afifo_wr_sched.sv
// Directed bench for afifo_wr_sched: reset, streaming, contention, FIFO-full stall,
// timeout padding and reset mid-burst, each checked against hand-computed values.
module tb_afifo_wr_sched;
    import afifo_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_ready;
    logic        fifo_wfull;
    logic        fifo_wren;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pad_cnt;
    logic [1:0]  state_dbg;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] word;
    int          cnt[4];
    int          src;

    afifo_wr_sched #(
        .N_REQ(4), .DW(8), .BURST(4), .TIMEOUT(16), .PAD_BYTE(8'h00), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_wren  (fifo_wren),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .pad_cnt    (pad_cnt),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive_data;
        for (int i = 0; i < 4; i++) s_data[i*8 +: 8] = 8'((i + 1) * 16 + cnt[i]);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        s_valid    = 4'hf;
        s_data     = '0;
        fifo_wfull = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;

        // Reset held 2 cycles with every source requesting
        tick;
        tick;
        settle;
        chk("rst_ready", s_ready, 0);
        chk("rst_wren", fifo_wren, 0);
        chk("rst_padcnt", pad_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_state", state_dbg, ST_IDLE);

        // Single source streams 01..08: two bursts with one IDLE bubble between
        rst = 1'b0;
        s_valid = 4'b0001;
        s_data[7:0] = 8'h01;
        settle;
        chk("t2_idle_wren", fifo_wren, 0);
        tick;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                s_data[7:0] = 8'h05;
                settle;
                chk("t2_bubble_busy", busy, 0);
                chk("t2_bubble_wren", fifo_wren, 0);
                tick;
            end
            s_data[7:0] = 8'(k);
            settle;
            chk("t2_wren", fifo_wren, 1);
            chk("t2_wdata", fifo_wdata, 32'(k));
            chk("t2_grant", grant_id, 0);
            chk("t2_ready", s_ready, 4'b0001);
            tick;
        end
        s_valid = 4'b0000;
        settle;
        chk("t2_end_busy", busy, 0);
        tick;

        // Contention: all four request, grant order 0,1,2,3,0, one source per word
        rst = 1'b1;
        tick;
        rst = 1'b0;
        s_valid = 4'hf;
        for (int b = 0; b < 5; b++) begin
            src = b % 4;
            drive_data;
            settle;
            chk("t3_bubble_wren", fifo_wren, 0);
            chk("t3_bubble_busy", busy, 0);
            tick;
            exp_q.push_back({8'((src + 1) * 16 + cnt[src] + 3), 8'((src + 1) * 16 + cnt[src] + 2),
                             8'((src + 1) * 16 + cnt[src] + 1), 8'((src + 1) * 16 + cnt[src])});
            word = '0;
            for (int k = 0; k < 4; k++) begin
                drive_data;
                settle;
                chk("t3_grant", grant_id, 32'(src));
                chk("t3_wren", fifo_wren, 1);
                chk("t3_ready", s_ready, 32'(1 << src));
                chk("t3_wdata", fifo_wdata, 32'(8'((src + 1) * 16 + cnt[src])));
                word = {fifo_wdata, word[31:8]};
                cnt[src]++;
                tick;
            end
            chk("t3_word", word, exp_q.pop_front());
        end
        s_valid = 4'b0000;
        tick;

        // FIFO full for 30 cycles at beat 2: stall is not charged, no PAD
        s_valid = 4'b0100;
        s_data[23:16] = 8'hC0;
        settle;
        chk("t4_idle_busy", busy, 0);
        tick;
        for (int k = 0; k < 2; k++) begin
            s_data[23:16] = 8'(8'hC0 + k);
            settle;
            chk("t4_wren", fifo_wren, 1);
            chk("t4_wdata", fifo_wdata, 32'(8'hC0 + k));
            chk("t4_grant", grant_id, 2);
            tick;
        end
        fifo_wfull = 1'b1;
        s_data[23:16] = 8'hC2;
        for (int k = 0; k < 30; k++) begin
            settle;
            chk("t4_full_wren", fifo_wren, 0);
            chk("t4_full_ready", s_ready, 0);
            chk("t4_full_state", state_dbg, ST_BURST);
            tick;
        end
        fifo_wfull = 1'b0;
        for (int k = 2; k < 4; k++) begin
            s_data[23:16] = 8'(8'hC0 + k);
            settle;
            chk("t4_resume_wren", fifo_wren, 1);
            chk("t4_resume_wdata", fifo_wdata, 32'(8'hC0 + k));
            tick;
        end
        s_valid = 4'b0000;
        settle;
        chk("t4_done_state", state_dbg, ST_IDLE);
        chk("t4_padcnt", pad_cnt, 0);
        tick;

        // Timeout: src1 sends AA,BB then stalls; 16 idle cycles, then two pad bytes
        s_valid = 4'b0010;
        s_data[15:8] = 8'hAA;
        settle;
        chk("t5_idle_wren", fifo_wren, 0);
        tick;
        exp_q.push_back(32'h0000_BBAA);
        word = '0;
        settle;
        chk("t5_grant", grant_id, 1);
        chk("t5_wdata_aa", fifo_wdata, 8'hAA);
        word = {fifo_wdata, word[31:8]};
        tick;
        s_data[15:8] = 8'hBB;
        settle;
        chk("t5_wdata_bb", fifo_wdata, 8'hBB);
        word = {fifo_wdata, word[31:8]};
        tick;
        s_valid = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            settle;
            chk("t5_wait_wren", fifo_wren, 0);
            chk("t5_wait_state", state_dbg, ST_BURST);
            tick;
        end
        for (int k = 0; k < 2; k++) begin
            settle;
            chk("t5_pad_state", state_dbg, ST_PAD);
            chk("t5_pad_wren", fifo_wren, 1);
            chk("t5_pad_wdata", fifo_wdata, 0);
            chk("t5_pad_ready", s_ready, 0);
            word = {fifo_wdata, word[31:8]};
            tick;
        end
        chk("t5_word", word, exp_q.pop_front());
        s_valid = 4'b0110;
        settle;
        chk("t5_after_padcnt", pad_cnt, 1);
        chk("t5_after_busy", busy, 0);
        tick;
        settle;
        chk("t5_next_grant", grant_id, 2);
        chk("t5_next_ready", s_ready, 4'b0100);
        s_valid = 4'b1100;
        tick;
        tick;
        tick;
        tick;

        // Reset at beat 1 of src3: rr pointer returns to 0, so src0 wins over src3
        settle;
        chk("t6_idle_busy", busy, 0);
        tick;
        settle;
        chk("t6_grant3", grant_id, 3);
        chk("t6_beat0_wren", fifo_wren, 1);
        tick;
        settle;
        chk("t6_beat1_wren", fifo_wren, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        s_valid = 4'b1001;
        settle;
        chk("t6_rst_state", state_dbg, ST_IDLE);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wren", fifo_wren, 0);
        chk("t6_rst_grant", grant_id, 0);
        chk("t6_rst_padcnt", pad_cnt, 0);
        tick;
        settle;
        chk("t6_regrant", grant_id, 0);
        chk("t6_regrant_busy", busy, 1);
        chk("t6_regrant_ready", s_ready, 4'b0001);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
